piece_bag_queue: RTL and testbench

PIECE_BAG_QUEUE -- requirements
Module: piece_bag_queue

---
 rtl/tetris_pkg.sv | 14 +
 rtl/piece_fifo.sv | 59 +++++
 rtl/piece_bag_queue.sv | 102 ++++++++++
 tb/tb_piece_bag_queue.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared piece types, bag size and controller state encoding.
package tetris_pkg;

    typedef logic [2:0] piece_t;

    localparam int     NUM_PIECES = 7;
    localparam piece_t INVALID_ID = 3'd7;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/piece_fifo.sv
// Circular buffer of upcoming piece IDs with look-ahead of the head and
// second entry as they will stand after the current edge.
module piece_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       push,
    input  logic [2:0] din,
    input  logic       pop,
    output logic [3:0] count,
    output logic [3:0] count_next,
    output logic [2:0] head_next,
    output logic [2:0] second_next
);
    import tetris_pkg::*;

    localparam int                PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]  LAST  = PTR_W'(DEPTH - 1);

    piece_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr_n;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Slot contents after this edge, including a write landing on that slot.
    function automatic piece_t peek(input logic [PTR_W-1:0] p);
        return (push && (p == wr_ptr)) ? din : mem[p];
    endfunction

    assign rd_ptr_n    = pop ? ptr_inc(rd_ptr) : rd_ptr;
    assign count_next  = count + {3'b000, push} - {3'b000, pop};
    assign head_next   = peek(rd_ptr_n);
    assign second_next = peek(ptr_inc(rd_ptr_n));

    // Storage, wrapping pointers and occupancy.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            rd_ptr <= rd_ptr_n;
            count  <= count_next;
        end
    end

endmodule

// File: rtl/piece_bag_queue.sv
// 7-bag piece generator: filters random IDs so each bag is a permutation,
// queues them, and presents the head and a one-entry preview.
//
//  state   | meaning
//  ST_INIT | filling the queue after reset; no piece offered, pops ignored
//  ST_RUN  | queue live; head offered while entries exist, until reset
module piece_bag_queue #(
    parameter int DEPTH      = 4,
    parameter int NUM_PIECES = tetris_pkg::NUM_PIECES
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [2:0] rnd,
    input  logic       rnd_valid,
    input  logic       pop,
    output logic [2:0] piece,
    output logic       piece_valid,
    output logic [2:0] next_piece,
    output logic [7:0] refills
);
    import tetris_pkg::*;

    localparam logic [3:0] DEPTH_C   = 4'(DEPTH);
    localparam logic [2:0] NP_C      = 3'(NUM_PIECES);
    localparam logic [7:0] FULL_MASK = 8'((1 << NUM_PIECES) - 1);

    state_t     state;
    state_t     state_n;
    logic [7:0] mask;
    logic [7:0] mask_set;
    logic       accept;
    logic       bag_done;
    logic       do_pop;
    logic [3:0] fifo_count;
    logic [3:0] fifo_count_next;
    piece_t     head_next;
    piece_t     second_next;
    logic       has_one;
    logic       has_two;

    // Fullness is judged on the occupancy at cycle start, so a pop never
    // makes room for a same-cycle push.
    assign accept   = rnd_valid && (fifo_count < DEPTH_C) && (rnd < NP_C) && !mask[rnd];
    assign mask_set = mask | (8'd1 << rnd);
    assign bag_done = accept && ((mask_set & FULL_MASK) == FULL_MASK);
    assign do_pop   = pop && piece_valid;
    assign has_one  = (fifo_count_next != 4'd0);
    assign has_two  = (fifo_count_next >= 4'd2);

    piece_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock       (clock),
        .resetn      (resetn),
        .push        (accept),
        .din         (rnd),
        .pop         (do_pop),
        .count       (fifo_count),
        .count_next  (fifo_count_next),
        .head_next   (head_next),
        .second_next (second_next)
    );

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_INIT;
        end else begin
            state <= state_n;
        end
    end

    // Next state: leave INIT on the edge the queue becomes full.
    always_comb begin
        state_n = state;
        if ((state == ST_INIT) && (fifo_count_next == DEPTH_C)) begin
            state_n = ST_RUN;
        end
    end

    // Bag mask, refill counter and registered head/preview outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mask        <= '0;
            refills     <= '0;
            piece       <= '0;
            piece_valid <= 1'b0;
            next_piece  <= '0;
        end else begin
            if (bag_done) begin
                mask    <= '0;
                refills <= refills + 8'd1;
            end else if (accept) begin
                mask    <= mask_set;
            end
            piece_valid <= (state_n == ST_RUN) && has_one;
            if ((state_n == ST_RUN) && has_one) begin
                piece <= head_next;
            end
            next_piece <= has_two ? second_next : 3'd0;
        end
    end

endmodule

// File: tb/tb_piece_bag_queue.sv
// Directed bench for piece_bag_queue with a scoreboard of expected heads.
module tb_piece_bag_queue;

    logic       clock;
    logic       resetn;
    logic [2:0] rnd;
    logic       rnd_valid;
    logic       pop;
    logic [2:0] piece;
    logic       piece_valid;
    logic [2:0] next_piece;
    logic [7:0] refills;

    int total_checks;
    int passed_checks;
    logic [2:0] exp_q[$];

    piece_bag_queue dut (
        .clock       (clock),
        .resetn      (resetn),
        .rnd         (rnd),
        .rnd_valid   (rnd_valid),
        .pop         (pop),
        .piece       (piece),
        .piece_valid (piece_valid),
        .next_piece  (next_piece),
        .refills     (refills)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        assert (observed === expected) passed_checks++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    // One cycle of stimulus; the bench states whether it expects the
    // candidate to be accepted and the head to be consumed.
    task automatic cyc(input logic rv, input logic [2:0] r, input logic p,
                       input bit exp_acc, input bit exp_pop);
        logic [2:0] want;
        @(negedge clock);
        rnd_valid = rv;
        rnd       = r;
        pop       = p;
        if (exp_pop) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                want = exp_q.pop_front();
                check("pop_head", 32'(piece), 32'(want));
            end
        end
        if (exp_acc) exp_q.push_back(r);
        @(posedge clock);
        #1;
        rnd_valid = 1'b0;
        pop       = 1'b0;
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        resetn    = 1'b0;
        rnd       = 3'd0;
        rnd_valid = 1'b0;
        pop       = 1'b0;
        #1;
        check("rst_piece", 32'(piece), 0);
        check("rst_valid", 32'(piece_valid), 0);
        check("rst_next", 32'(next_piece), 0);
        check("rst_refills", 32'(refills), 0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;

        // Initial fill: 3,3,7,1,5,0 with an ignored pop at two entries.
        cyc(1, 3'd3, 0, 1, 0);
        check("init_valid_1", 32'(piece_valid), 0);
        cyc(1, 3'd3, 0, 0, 0);
        cyc(1, 3'd7, 0, 0, 0);
        cyc(1, 3'd1, 0, 1, 0);
        cyc(0, 3'd0, 1, 0, 0);
        check("init_pop_valid", 32'(piece_valid), 0);
        cyc(1, 3'd5, 0, 1, 0);
        check("init_valid_3", 32'(piece_valid), 0);
        cyc(1, 3'd0, 0, 1, 0);
        check("run_piece", 32'(piece), 3);
        check("run_next", 32'(next_piece), 1);
        check("run_valid", 32'(piece_valid), 1);

        // Unused ID offered to a full queue is rejected.
        cyc(1, 3'd6, 0, 0, 0);
        check("full_rej_piece", 32'(piece), 3);
        check("full_rej_next", 32'(next_piece), 1);
        check("full_rej_refills", 32'(refills), 0);

        // Pop while feeding 2,4,6; the first 2 meets a full queue.
        cyc(1, 3'd2, 1, 0, 1);
        check("full_pop_next", 32'(next_piece), 5);
        cyc(1, 3'd2, 1, 1, 1);
        cyc(1, 3'd4, 1, 1, 1);
        cyc(1, 3'd6, 0, 1, 0);
        check("bag1_refills", 32'(refills), 1);
        check("bag1_piece", 32'(piece), 0);
        check("bag1_next", 32'(next_piece), 2);

        // Drain with no candidates; queue holds 0,2,4,6.
        repeat (4) cyc(0, 3'd0, 1, 0, 1);
        check("drain_valid", 32'(piece_valid), 0);
        check("drain_piece_hold", 32'(piece), 6);
        check("drain_next", 32'(next_piece), 0);
        cyc(0, 3'd0, 1, 0, 0);
        check("fifth_pop_valid", 32'(piece_valid), 0);
        check("fifth_pop_piece", 32'(piece), 6);
        cyc(1, 3'd2, 0, 1, 0);
        check("empty_push_piece", 32'(piece), 2);
        check("empty_push_valid", 32'(piece_valid), 1);

        // Second bag: fill, reject when full, pop, complete the bag.
        cyc(1, 3'd0, 0, 1, 0);
        cyc(1, 3'd1, 0, 1, 0);
        cyc(1, 3'd3, 0, 1, 0);
        cyc(1, 3'd4, 0, 0, 0);
        check("full2_next", 32'(next_piece), 0);
        repeat (3) cyc(0, 3'd0, 1, 0, 1);
        cyc(1, 3'd4, 0, 1, 0);
        cyc(1, 3'd5, 0, 1, 0);
        cyc(1, 3'd6, 0, 1, 0);
        check("bag2_refills", 32'(refills), 2);
        cyc(0, 3'd0, 1, 0, 1);
        check("three_piece", 32'(piece), 4);
        check("three_next", 32'(next_piece), 5);

        // Asynchronous reset between edges.
        @(negedge clock);
        #2;
        resetn = 1'b0;
        #1;
        check("async_piece", 32'(piece), 0);
        check("async_valid", 32'(piece_valid), 0);
        check("async_next", 32'(next_piece), 0);
        check("async_refills", 32'(refills), 0);
        exp_q.delete();
        @(negedge clock);
        resetn = 1'b1;

        // Fresh fill after reset.
        cyc(1, 3'd1, 0, 1, 0);
        check("refill_valid", 32'(piece_valid), 0);
        check("refill_refills", 32'(refills), 0);
        cyc(1, 3'd2, 0, 1, 0);
        cyc(1, 3'd3, 0, 1, 0);
        cyc(1, 3'd4, 0, 1, 0);
        check("refill_piece", 32'(piece), 1);
        check("refill_next", 32'(next_piece), 2);
        check("refill_run_valid", 32'(piece_valid), 1);
        repeat (4) cyc(0, 3'd0, 1, 0, 1);
        check("final_valid", 32'(piece_valid), 0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
